// File: rtl/phy_pkg.sv
// Shared definitions for the serial lane receiver: FSM encoding and default symbols.
package phy_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StAlign,
    StLocked
  } rx_state_e;

  localparam logic [7:0] ComDefault = 8'hBC;
  localparam logic [7:0] IdlDefault = 8'h7C;

  // Lane pointer width; a single lane still needs a one-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lane_demux.sv
// Distributes received symbols round-robin over NLANES output registers.
module lane_demux
  import phy_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NLANES = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [WIDTH-1:0]                 sym_i,
  input  logic                             sym_valid_i,
  input  logic                             ptr_clr_i,
  output logic [NLANES*WIDTH-1:0]          data_o,
  output logic [NLANES-1:0]                valid_o,
  output logic [ptr_width(NLANES)-1:0]     lane_ptr_o
);

  localparam int unsigned PtrW = ptr_width(NLANES);

  logic [NLANES*WIDTH-1:0] data_q;
  logic [NLANES-1:0]       valid_q;
  logic [PtrW-1:0]         ptr_q;

  // Write the addressed lane, pulse its valid bit and advance the pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= '0;
      if (sym_valid_i) begin
        for (int i = 0; i < NLANES; i++) begin
          if (ptr_q == PtrW'(i)) begin
            data_q[i*WIDTH +: WIDTH] <= sym_i;
            valid_q[i]               <= 1'b1;
          end
        end
        if (ptr_q == PtrW'(NLANES - 1)) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= ptr_q + 1'b1;
        end
      end else if (ptr_clr_i) begin
        ptr_q <= '0;
      end
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign lane_ptr_o = ptr_q;

endmodule

// File: rtl/serial_lane_rx.sv
// Serial receiver: finds symbol alignment on COM, locks after LOCK_CNT aligned COMs,
// and forwards non-COM/non-idle symbols to the lane demultiplexer.
module serial_lane_rx
  import phy_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       NLANES      = 4,
  parameter logic [WIDTH-1:0]  COM         = WIDTH'(ComDefault),
  parameter logic [WIDTH-1:0]  IDL         = WIDTH'(IdlDefault),
  parameter int unsigned       LOCK_CNT    = 4,
  parameter int unsigned       COM_TIMEOUT = 64
) (
  input  logic                          clk_32f,
  input  logic                          reset,
  input  logic                          data_in,
  output logic [NLANES*WIDTH-1:0]       data_out,
  output logic [NLANES-1:0]             valid_out,
  output logic                          active,
  output logic [ptr_width(NLANES)-1:0]  lane_ptr,
  output logic                          sym_err
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam int unsigned ComW = $clog2(LOCK_CNT + 1);
  localparam int unsigned GapW = $clog2(COM_TIMEOUT + 1);

  rx_state_e        state_q;
  logic [WIDTH-2:0] sr_q;
  logic [BitW-1:0]  bit_cnt_q;
  logic [ComW-1:0]  com_cnt_q;
  logic [GapW-1:0]  gap_q;
  logic             active_q;
  logic             sym_err_q;

  logic [WIDTH-1:0] cand;
  logic             boundary;
  logic             is_com;
  logic             is_idl;
  logic             timeout;
  logic             lock_enter;
  logic             sym_fwd;
  logic             ptr_clr;

  // Candidate symbol decode and strobes towards the lane demux.
  always_comb begin
    cand       = {sr_q, data_in};
    boundary   = (bit_cnt_q == BitW'(WIDTH - 1));
    is_com     = (cand == COM);
    is_idl     = (cand == IDL);
    timeout    = (state_q == StLocked) && boundary && !is_com &&
                 (gap_q == GapW'(COM_TIMEOUT - 1));
    lock_enter = ((state_q == StHunt) && is_com && (LOCK_CNT == 1)) ||
                 ((state_q == StAlign) && boundary && is_com &&
                  (com_cnt_q == ComW'(LOCK_CNT - 1)));
    sym_fwd    = (state_q == StLocked) && boundary && !is_com && !is_idl && !timeout;
    // Lane pointer restarts on lock entry, on every locked COM and on timeout.
    ptr_clr    = lock_enter || ((state_q == StLocked) && boundary && (is_com || timeout));
  end

  // Alignment FSM with bit/COM/gap counters and registered status outputs.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q   <= StHunt;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      gap_q     <= '0;
      active_q  <= 1'b0;
      sym_err_q <= 1'b0;
    end else begin
      sr_q      <= cand[WIDTH-2:0];
      sym_err_q <= 1'b0;
      bit_cnt_q <= boundary ? '0 : bit_cnt_q + 1'b1;
      case (state_q)
        StHunt: begin
          // Bit phase is meaningless until a COM is seen at some offset.
          bit_cnt_q <= '0;
          if (is_com) begin
            com_cnt_q <= ComW'(1);
            gap_q     <= '0;
            if (lock_enter) begin
              state_q  <= StLocked;
              active_q <= 1'b1;
            end else begin
              state_q <= StAlign;
            end
          end
        end
        StAlign: begin
          if (boundary) begin
            if (is_com) begin
              com_cnt_q <= com_cnt_q + 1'b1;
              if (lock_enter) begin
                state_q  <= StLocked;
                active_q <= 1'b1;
                gap_q    <= '0;
              end
            end else begin
              state_q   <= StHunt;
              com_cnt_q <= '0;
            end
          end
        end
        StLocked: begin
          if (boundary) begin
            if (is_com) begin
              gap_q <= '0;
            end else if (timeout) begin
              state_q   <= StHunt;
              active_q  <= 1'b0;
              sym_err_q <= 1'b1;
              gap_q     <= '0;
              com_cnt_q <= '0;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

  lane_demux #(
    .WIDTH  (WIDTH),
    .NLANES (NLANES)
  ) u_lane_demux (
    .clk_i       (clk_32f),
    .rst_ni      (reset),
    .sym_i       (cand),
    .sym_valid_i (sym_fwd),
    .ptr_clr_i   (ptr_clr),
    .data_o      (data_out),
    .valid_o     (valid_out),
    .lane_ptr_o  (lane_ptr)
  );

  assign active  = active_q;
  assign sym_err = sym_err_q;

endmodule

// File: tb/tb_serial_lane_rx.sv
// Bench for serial_lane_rx: two instances (8b/4 lanes and 10b/2 lanes) checked every
// cycle against a symbol-level reference model, plus directed literal expectations.
module tb_serial_lane_rx;

  localparam int unsigned WA = 8;
  localparam int unsigned NA = 4;
  localparam int unsigned WB = 10;
  localparam int unsigned NB = 2;
  localparam logic [WB-1:0] COMB = 10'h17C;
  localparam int LK = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_a = 1'b0;
  logic din_b = 1'b0;
  logic chk_en = 1'b0;

  logic [NA*WA-1:0] dout_a;
  logic [NA-1:0]    vld_a;
  logic             act_a;
  logic             err_a;
  logic [1:0]       ptr_a;
  logic [NB*WB-1:0] dout_b;
  logic [NB-1:0]    vld_b;
  logic             act_b;
  logic             err_b;
  logic [0:0]       ptr_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_lane_rx dut_a (
    .clk_32f   (clk),
    .reset     (rst_n),
    .data_in   (din_a),
    .data_out  (dout_a),
    .valid_out (vld_a),
    .active    (act_a),
    .lane_ptr  (ptr_a),
    .sym_err   (err_a)
  );

  serial_lane_rx #(
    .WIDTH  (WB),
    .NLANES (NB),
    .COM    (COMB)
  ) dut_b (
    .clk_32f   (clk),
    .reset     (rst_n),
    .data_in   (din_b),
    .data_out  (dout_b),
    .valid_out (vld_b),
    .active    (act_b),
    .lane_ptr  (ptr_b),
    .sym_err   (err_b)
  );

  // Reference model: mode 0 = searching, 1 = counting COMs, 2 = locked.
  int          cfg_w   [2] = '{8, 10};
  int          cfg_n   [2] = '{4, 2};
  int unsigned cfg_com [2] = '{32'hBC, 32'h17C};
  int unsigned cfg_idl [2] = '{32'h7C, 32'h7C};

  int          m_mode  [2];
  int          m_phase [2];
  int          m_coms  [2];
  int          m_gap   [2];
  int          m_ptr   [2];
  int unsigned m_win   [2];
  int unsigned m_lane  [2][8];
  int unsigned m_vmask [2];
  bit          m_act   [2];
  bit          m_err   [2];

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_phase[k] = 0; m_coms[k] = 0; m_gap[k] = 0; m_ptr[k] = 0;
      m_win[k] = 0; m_vmask[k] = 0; m_act[k] = 0; m_err[k] = 0;
      for (int i = 0; i < 8; i++) m_lane[k][i] = 0;
    end
  endtask

  task automatic mdl_step(input int k, input bit din);
    int unsigned sym;
    bit at_end;
    sym = ((m_win[k] << 1) | 32'(din)) & ((32'd1 << cfg_w[k]) - 1);
    m_win[k] = sym;
    m_vmask[k] = 0;
    m_err[k] = 0;
    if (m_mode[k] == 0) begin
      if (sym == cfg_com[k]) begin
        m_phase[k] = 0;
        m_coms[k] = 1;
        m_gap[k] = 0;
        if (LK == 1) begin m_mode[k] = 2; m_act[k] = 1; m_ptr[k] = 0; end
        else m_mode[k] = 1;
      end
      return;
    end
    at_end = (m_phase[k] == cfg_w[k] - 1);
    m_phase[k] = at_end ? 0 : m_phase[k] + 1;
    if (!at_end) return;
    if (m_mode[k] == 1) begin
      if (sym == cfg_com[k]) begin
        m_coms[k]++;
        if (m_coms[k] == LK) begin m_mode[k] = 2; m_act[k] = 1; m_gap[k] = 0; m_ptr[k] = 0; end
      end else begin
        m_mode[k] = 0;
        m_coms[k] = 0;
      end
    end else begin
      if (sym == cfg_com[k]) begin
        m_ptr[k] = 0;
        m_gap[k] = 0;
      end else begin
        m_gap[k]++;
        if (m_gap[k] == TO) begin
          m_mode[k] = 0; m_act[k] = 0; m_err[k] = 1; m_ptr[k] = 0; m_gap[k] = 0; m_coms[k] = 0;
        end else if (sym != cfg_idl[k]) begin
          m_lane[k][m_ptr[k]] = sym;
          m_vmask[k] = 32'd1 << m_ptr[k];
          m_ptr[k] = (m_ptr[k] + 1) % cfg_n[k];
        end
      end
    end
  endtask

  function automatic logic [63:0] mdl_pack(input int k);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < cfg_n[k]; i++) p = p | (64'(m_lane[k][i]) << (i * cfg_w[k]));
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_reset();
    end else begin
      mdl_step(0, din_a);
      mdl_step(1, din_b);
    end
  end

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a.data_out", 64'(dout_a), mdl_pack(0));
      cmp("a.valid_out", 64'(vld_a), 64'(m_vmask[0]));
      cmp("a.active", 64'(act_a), 64'(m_act[0]));
      cmp("a.lane_ptr", 64'(ptr_a), 64'(m_ptr[0]));
      cmp("a.sym_err", 64'(err_a), 64'(m_err[0]));
      cmp("b.data_out", 64'(dout_b), mdl_pack(1));
      cmp("b.valid_out", 64'(vld_b), 64'(m_vmask[1]));
      cmp("b.active", 64'(act_b), 64'(m_act[1]));
      cmp("b.lane_ptr", 64'(ptr_b), 64'(m_ptr[1]));
      cmp("b.sym_err", 64'(err_b), 64'(m_err[1]));
    end
  end

  bit qa[$];
  bit qb[$];

  task automatic send_bit_a(input bit b);
    @(negedge clk);
    din_a = b;
    din_b = 1'b0;
  endtask

  task automatic send_sym(input int k, input int unsigned v);
    for (int i = cfg_w[k] - 1; i >= 0; i--) begin
      @(negedge clk);
      din_a = (k == 0) ? v[i] : 1'b0;
      din_b = (k == 1) ? v[i] : 1'b0;
    end
  endtask

  task automatic after_sym();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    din_a = 1'b0;
    din_b = 1'b0;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic int unsigned rand_data(input int k);
    int unsigned v;
    do v = $urandom_range(0, (1 << cfg_w[k]) - 1);
    while (v == cfg_com[k] || v == cfg_idl[k]);
    return v;
  endfunction

  task automatic push_sym(input int k, input int unsigned v);
    for (int i = cfg_w[k] - 1; i >= 0; i--) begin
      if (k == 0) qa.push_back(v[i]);
      else qb.push_back(v[i]);
    end
  endtask

  task automatic gen_stream(input int k, input int nsym);
    int r;
    for (int j = 0; j < LK; j++) push_sym(k, cfg_com[k]);
    for (int j = 0; j < nsym; j++) begin
      r = $urandom_range(0, 99);
      if (r < 30) push_sym(k, cfg_com[k]);
      else if (r < 40) push_sym(k, cfg_idl[k]);
      else if (r < 45) begin
        repeat ($urandom_range(1, 3)) begin
          if (k == 0) qa.push_back(1'($urandom_range(0, 1)));
          else qb.push_back(1'($urandom_range(0, 1)));
        end
      end else if (r < 47) begin
        repeat (TO + 6) push_sym(k, rand_data(k));
      end else push_sym(k, rand_data(k));
    end
  endtask

  task automatic run_random();
    gen_stream(0, 350);
    gen_stream(1, 350);
    while (qa.size() > 0 || qb.size() > 0) begin
      @(negedge clk);
      din_a = (qa.size() > 0) ? qa.pop_front() : 1'b0;
      din_b = (qb.size() > 0) ? qb.pop_front() : 1'b0;
    end
  endtask

  logic [3:0]  exp_v4 [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [1:0]  exp_v2 [5] = '{2'h1, 2'h2, 2'h1, 2'h2, 2'h1};
  int unsigned seq5   [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    cmp("rst.data_a", 64'(dout_a), 64'h0);
    cmp("rst.active_a", 64'(act_a), 64'h0);
    cmp("rst.ptr_a", 64'(ptr_a), 64'h0);

    // Lock after three garbage bits and four COMs.
    send_bit_a(1'b1);
    send_bit_a(1'b0);
    send_bit_a(1'b1);
    for (int i = 0; i < 3; i++) begin
      send_sym(0, 32'hBC);
      after_sym();
      cmp("align.active", 64'(act_a), 64'h0);
    end
    send_sym(0, 32'hBC);
    cmp("lock.pre_edge", 64'(act_a), 64'h0);
    after_sym();
    cmp("lock.active", 64'(act_a), 64'h1);
    cmp("lock.valid", 64'(vld_a), 64'h0);

    // Round-robin over four lanes.
    for (int i = 0; i < 5; i++) begin
      send_sym(0, seq5[i]);
      after_sym();
      cmp("rr4.valid", 64'(vld_a), 64'(exp_v4[i]));
    end
    cmp("rr4.data", 64'(dout_a), 64'h4433_2255);

    // Idle skipped, COM resets the pointer.
    send_sym(0, 32'hBC);
    after_sym();
    cmp("com.ptr", 64'(ptr_a), 64'h0);
    send_sym(0, 32'h11);
    after_sym();
    cmp("seq.11.valid", 64'(vld_a), 64'h1);
    send_sym(0, 32'h7C);
    after_sym();
    cmp("seq.idl.valid", 64'(vld_a), 64'h0);
    cmp("seq.idl.ptr", 64'(ptr_a), 64'h1);
    send_sym(0, 32'h22);
    after_sym();
    cmp("seq.22.valid", 64'(vld_a), 64'h2);
    send_sym(0, 32'hBC);
    after_sym();
    cmp("seq.com.ptr", 64'(ptr_a), 64'h0);
    send_sym(0, 32'h33);
    after_sym();
    cmp("seq.33.valid", 64'(vld_a), 64'h1);
    cmp("seq.data", 64'(dout_a), 64'h4433_2233);

    // COM timeout.
    send_sym(0, 32'hBC);
    for (int i = 0; i < TO - 1; i++) send_sym(0, rand_data(0));
    after_sym();
    cmp("to.still_active", 64'(act_a), 64'h1);
    send_sym(0, rand_data(0));
    after_sym();
    cmp("to.sym_err", 64'(err_a), 64'h1);
    cmp("to.active", 64'(act_a), 64'h0);
    cmp("to.valid", 64'(vld_a), 64'h0);
    cmp("to.ptr", 64'(ptr_a), 64'h0);

    // Alignment broken by a non-COM symbol.
    pulse_reset();
    release_reset();
    send_sym(0, 32'hBC);
    send_sym(0, 32'hBC);
    send_sym(0, 32'h00);
    after_sym();
    cmp("abort.active", 64'(act_a), 64'h0);
    cmp("abort.sym_err", 64'(err_a), 64'h0);

    // Asynchronous reset while locked, partial symbol in flight.
    for (int i = 0; i < LK; i++) send_sym(0, 32'hBC);
    send_sym(0, 32'h11);
    send_sym(0, 32'h22);
    send_bit_a(1'b0);
    send_bit_a(1'b0);
    send_bit_a(1'b1);
    pulse_reset();
    cmp("arst.data", 64'(dout_a), 64'h0);
    cmp("arst.active", 64'(act_a), 64'h0);
    cmp("arst.ptr", 64'(ptr_a), 64'h0);
    cmp("arst.valid", 64'(vld_a), 64'h0);
    release_reset();
    for (int i = 0; i < LK - 1; i++) send_sym(0, 32'hBC);
    after_sym();
    cmp("relock.partial", 64'(act_a), 64'h0);
    send_sym(0, 32'hBC);
    after_sym();
    cmp("relock.full", 64'(act_a), 64'h1);

    // Ten-bit symbols over two lanes.
    for (int i = 0; i < LK; i++) send_sym(1, 32'h17C);
    after_sym();
    cmp("b.lock", 64'(act_b), 64'h1);
    for (int i = 0; i < 5; i++) begin
      send_sym(1, seq5[i]);
      after_sym();
      cmp("rr2.valid", 64'(vld_b), 64'(exp_v2[i]));
    end
    cmp("rr2.data", 64'(dout_b), 64'h1_1055);

    // Randomized traffic, with a reset between two rounds.
    run_random();
    pulse_reset();
    release_reset();
    run_random();
    repeat (4) @(posedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_lane_rx.md
SERIAL_LANE_RX -- requirements
Module: serial_lane_rx

Interface
REQ-001 Parameter WIDTH, default 8: symbol width in bits.
REQ-002 Parameter NLANES, default 4: number of output lanes (power of two, 1..8).
REQ-003 Parameter COM, default 8'hBC: alignment/comma symbol.
REQ-004 Parameter IDL, default 8'h7C: idle symbol, never forwarded.
REQ-005 Parameter LOCK_CNT, default 4: consecutive aligned COMs required for lock (1..15).
REQ-006 Parameter COM_TIMEOUT, default 64: maximum symbol periods between COMs while locked (2..255).
REQ-007 clk_32f  input  1  single bit clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 data_in  input  1  serial data, MSB first, one bit per clk_32f.
REQ-010 data_out  output  NLANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH], registered, holds last written value.
REQ-011 valid_out  output  NLANES  bit i pulses high one cycle when lane i is written.
REQ-012 active  output  1  high while in LOCKED.
REQ-013 lane_ptr  output  log2(NLANES) (min 1)  next lane to be written.
REQ-014 sym_err  output  1  one-cycle pulse on loss of lock.

Function
REQ-015 Shift register sr SHALL shift in data_in each cycle; candidate symbol cand = {sr[WIDTH-2:0], data_in}.
REQ-016 FSM states SHALL be HUNT, ALIGN, LOCKED.
REQ-017 HUNT: every cycle cand==COM -> bit_cnt=0, com_cnt=1, go ALIGN (or LOCKED if LOCK_CNT==1); bit-level alignment at any offset.
REQ-018 Symbol boundary SHALL be the cycle bit_cnt==WIDTH-1; bit_cnt wraps to 0 there.
REQ-019 ALIGN: at boundary, cand==COM -> com_cnt+1, reaching LOCK_CNT -> LOCKED; cand!=COM -> HUNT, com_cnt=0, no sym_err.
REQ-020 LOCKED, at boundary: cand==COM -> lane_ptr=0, gap counter=0, nothing forwarded.
REQ-021 LOCKED, at boundary: cand==IDL -> nothing forwarded, lane_ptr unchanged.
REQ-022 LOCKED, at boundary: other cand -> data_out lane lane_ptr=cand, valid_out[lane_ptr]=1, lane_ptr=(lane_ptr+1) mod NLANES.
REQ-023 Latency: data_out/valid_out/active update at the edge sampling the symbol's last bit; visible next cycle.
REQ-024 Gap counter SHALL count non-COM boundaries in LOCKED; reaching COM_TIMEOUT -> HUNT, active=0, sym_err=1 one cycle, lane_ptr=0, that symbol not forwarded.
REQ-025 valid_out SHALL be all-zero on non-boundary cycles and in HUNT/ALIGN; at most one bit high per cycle.
REQ-026 COM appearing mid-symbol (off-boundary) while LOCKED SHALL be ignored.

Reset
REQ-027 reset low SHALL immediately force: state HUNT, sr=0, bit_cnt=0, com_cnt=0, gap=0, lane_ptr=0, data_out=0, valid_out=0, active=0, sym_err=0.
REQ-028 reset asserted mid-symbol or mid-lock SHALL discard partial symbol; after release, full LOCK_CNT COMs needed again.

Structure
REQ-029 State encoding and default COM/IDL constants SHALL live in shared package phy_pkg.
REQ-030 One sub-module SHALL exist: lane_demux (lane_ptr, per-lane registers, valid_out decode), taking a symbol+strobe+COM-reset.
REQ-031 Widths derived from parameters via $clog2; no hard-coded 8 or 4.

Verification
REQ-032 Four 8'hBC after 3 garbage bits -> active rises at edge of 4th BC last bit; valid_out stays 0.
REQ-033 Locked, send 11,22,33,44,55 -> lanes 0..3 = 11,22,33,44, lane0=55, valid_out one-hot 1,2,4,8,1.
REQ-034 Locked, send 11,7C,22,BC,33 -> lane0=11, lane1=22, then BC resets ptr, lane0=33.
REQ-035 Locked, 64 symbols without BC -> sym_err pulse, active=0, 64th symbol not forwarded.
REQ-036 ALIGN after 2 BCs, then 8'h00 -> HUNT, active stays 0; reset pulse while locked -> all outputs 0 asynchronously.
REQ-037 Repeat REQ-033 with NLANES=2, WIDTH=10, COM=10'h17C.
